// File: rtl/router_input_unit_param.sv
// -----------------------------------------------------------------------------
// router_input_unit_param
//
// Per-port input unit for the mesh router. Incoming flits are steered into one
// of NUM_VC first-word-fall-through FIFOs (DEPTH entries each) by the VC field
// in the flit MSBs. The heads of the eligible VCs are arbitrated round-robin
// onto a single crossbar request. The presented head carries its XY route
// decision on out_req and has the hop field it is consuming decremented.
//
// With POLARITY_EN=1 the unit keeps the legacy two-phase behaviour: in each
// cycle, VCs of one parity accept flits while VCs of the other parity drain.
//
// Flit layout (MSB side):
//   vc    = [DATA_W-1 -: VCB]
//   dir_x = [DATA_W-VCB-1]          0 = right, 1 = left
//   dir_y = [DATA_W-VCB-2]          0 = up,    1 = down
//   hop_x = [DATA_W-9 -: HOP_W]
//   hop_y = [DATA_W-9-HOP_W -: HOP_W]
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   si           in   upstream flit valid
//   di           in   upstream flit
//   ri           out  per-VC ready to upstream (registered state only)
//   out_valid    out  a head flit is presented to the crossbar
//   out_data     out  presented flit, consumed hop field decremented
//   out_req      out  one-hot destination [0]up [1]down [2]left [3]right [4]NIC
//   out_vc       out  VC of the presented flit
//   out_grant    in   crossbar takes the presented flit this cycle
//   polarity     out  current phase
//   err_overflow out  sticky: a flit arrived for a full or ineligible VC
// -----------------------------------------------------------------------------
module router_input_unit_param #(
  parameter int unsigned  DATA_W      = 64,
  parameter int unsigned  NUM_VC      = 2,
  parameter int unsigned  DEPTH       = 2,
  parameter int unsigned  HOP_W       = 4,
  parameter bit           POLARITY_EN = 1'b1,
  localparam int unsigned VCB         = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si,
  input  logic [DATA_W-1:0] di,
  output logic [NUM_VC-1:0] ri,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_req,
  output logic [VCB-1:0]    out_vc,
  input  logic              out_grant,
  output logic              polarity,
  output logic              err_overflow
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned DX_BIT = DATA_W - VCB - 1;
  localparam int unsigned DY_BIT = DATA_W - VCB - 2;
  localparam int unsigned HX_MSB = DATA_W - 9;
  localparam int unsigned HY_MSB = DATA_W - 9 - HOP_W;

  localparam logic [4:0] REQ_UP    = 5'b00001;
  localparam logic [4:0] REQ_DOWN  = 5'b00010;
  localparam logic [4:0] REQ_LEFT  = 5'b00100;
  localparam logic [4:0] REQ_RIGHT = 5'b01000;
  localparam logic [4:0] REQ_NIC   = 5'b10000;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q    [NUM_VC][DEPTH];
  logic [PW-1:0]     wr_ptr_q [NUM_VC];
  logic [PW-1:0]     wr_ptr_d [NUM_VC];
  logic [PW-1:0]     rd_ptr_q [NUM_VC];
  logic [PW-1:0]     rd_ptr_d [NUM_VC];
  logic [CW-1:0]     count_q  [NUM_VC];
  logic [CW-1:0]     count_d  [NUM_VC];
  logic [VCB-1:0]    rr_ptr_q, rr_ptr_d;
  logic              polarity_q, polarity_d;
  logic              err_q, err_d;

  // ---------------------------------------------------------------------------
  // Per-VC status and phase masks
  // ---------------------------------------------------------------------------
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] nonempty;
  logic [NUM_VC-1:0] phase_in;
  logic [NUM_VC-1:0] phase_out;
  logic [NUM_VC-1:0] elig;

  always_comb begin
    full      = '0;
    nonempty  = '0;
    phase_in  = '0;
    phase_out = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]      = (count_q[v] == CW'(DEPTH));
      nonempty[v]  = (count_q[v] != '0);
      // A VC drains in the phase matching its parity and accepts in the other.
      phase_out[v] = !POLARITY_EN || (((v % 2) == 1) == polarity_q);
      phase_in[v]  = !POLARITY_EN || (((v % 2) == 1) != polarity_q);
    end
  end

  assign elig = nonempty & phase_out;

  // Gated by the reset level so upstream sees no credit while reset is held.
  assign ri = reset ? (~full & phase_in) : '0;

  // ---------------------------------------------------------------------------
  // Upstream push
  // ---------------------------------------------------------------------------
  logic [VCB-1:0]    in_vc;
  logic              accept;
  logic              drop;
  logic [NUM_VC-1:0] push_vec;

  assign in_vc  = di[DATA_W-1 -: VCB];
  assign accept = si && ri[in_vc];
  assign drop   = si && !ri[in_vc];

  always_comb begin
    push_vec = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_vec[v] = accept && (in_vc == VCB'(v));
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration starting at rr_ptr
  // ---------------------------------------------------------------------------
  logic           sel_valid;
  logic [VCB-1:0] sel_vc;
  logic [VCB-1:0] cand;

  always_comb begin
    sel_valid = 1'b0;
    sel_vc    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      // NUM_VC is a power of two, so the VCB-bit add wraps modulo NUM_VC.
      cand = rr_ptr_q + VCB'(i);
      if (!sel_valid && elig[cand]) begin
        sel_valid = 1'b1;
        sel_vc    = cand;
      end
    end
  end

  logic              pop;
  logic [NUM_VC-1:0] pop_vec;

  assign pop = sel_valid && out_grant;

  always_comb begin
    pop_vec = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop_vec[v] = pop && (sel_vc == VCB'(v));
    end
  end

  // ---------------------------------------------------------------------------
  // Route computation on the selected head
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] head;
  logic [HOP_W-1:0]  hop_x;
  logic [HOP_W-1:0]  hop_y;

  assign head  = mem_q[sel_vc][rd_ptr_q[sel_vc]];
  assign hop_x = head[HX_MSB -: HOP_W];
  assign hop_y = head[HY_MSB -: HOP_W];

  always_comb begin
    out_valid = sel_valid;
    out_vc    = '0;
    out_req   = '0;
    out_data  = '0;
    if (sel_valid) begin
      out_vc   = sel_vc;
      out_data = head;
      if (hop_x != '0) begin
        out_req                     = head[DX_BIT] ? REQ_LEFT : REQ_RIGHT;
        out_data[HX_MSB -: HOP_W]   = hop_x - HOP_W'(1);
      end else if (hop_y != '0) begin
        out_req                     = head[DY_BIT] ? REQ_DOWN : REQ_UP;
        out_data[HY_MSB -: HOP_W]   = hop_y - HOP_W'(1);
      end else begin
        out_req = REQ_NIC;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d   = pop ? sel_vc + VCB'(1) : rr_ptr_q;
    polarity_d = ~polarity_q;
    err_d      = err_q | drop;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = push_vec[v] ? wr_ptr_q[v] + PW'(1) : wr_ptr_q[v];
      rd_ptr_d[v] = pop_vec[v] ? rd_ptr_q[v] + PW'(1) : rd_ptr_q[v];
      case ({push_vec[v], pop_vec[v]})
        2'b10:   count_d[v] = count_q[v] + CW'(1);
        2'b01:   count_d[v] = count_q[v] - CW'(1);
        default: count_d[v] = count_q[v];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      rr_ptr_q   <= '0;
      polarity_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
      end
      rr_ptr_q   <= rr_ptr_d;
      polarity_q <= polarity_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible through non-zero counts.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_vec[v]) begin
        mem_q[v][wr_ptr_q[v]] <= di;
      end
    end
  end

  assign polarity     = polarity_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_router_input_unit_param.sv
// Bench for router_input_unit_param. Instance A uses the defaults (2 VCs,
// polarity phasing); instance B uses 4 VCs x 4 entries with phasing off.
// One instance is active at a time; a queue-per-VC model predicts every output.
module tb_router_input_unit_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_a, si_b;
  logic [63:0] di;
  logic        grant;

  logic [1:0]  a_ri;
  logic        a_valid;
  logic [63:0] a_data;
  logic [4:0]  a_req;
  logic        a_vc;
  logic        a_pol, a_err;

  logic [3:0]  b_ri;
  logic        b_valid;
  logic [63:0] b_data;
  logic [4:0]  b_req;
  logic [1:0]  b_vc;
  logic        b_pol, b_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit act;

  // Reference model state
  logic [63:0] mq [4][$];
  int          m_rr;
  int          m_pol;
  bit          m_err;
  bit          e_valid;
  int          e_vc;
  logic [4:0]  e_req;
  logic [63:0] e_data;
  logic [3:0]  e_ri;
  bit          cur_s, cur_g;
  logic [63:0] cur_d;

  always #5 clk = ~clk;

  router_input_unit_param u_dut_a (
    .clk(clk), .reset(reset), .si(si_a), .di(di), .ri(a_ri), .out_valid(a_valid),
    .out_data(a_data), .out_req(a_req), .out_vc(a_vc), .out_grant(grant),
    .polarity(a_pol), .err_overflow(a_err)
  );

  router_input_unit_param #(.NUM_VC(4), .DEPTH(4), .POLARITY_EN(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .si(si_b), .di(di), .ri(b_ri), .out_valid(b_valid),
    .out_data(b_data), .out_req(b_req), .out_vc(b_vc), .out_grant(grant),
    .polarity(b_pol), .err_overflow(b_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < 4; v++) mq[v].delete();
    m_rr  = 0;
    m_pol = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_eval();
    int nvc, depth, vcb, v;
    bit pol_en;
    logic [63:0] head;
    logic [3:0] hx, hy;
    nvc    = act ? 4 : 2;
    depth  = act ? 4 : 2;
    vcb    = act ? 2 : 1;
    pol_en = !act;
    e_valid = 1'b0; e_vc = 0; e_req = '0; e_data = '0; e_ri = '0;
    for (int k = 0; k < nvc; k++)
      e_ri[k] = (mq[k].size() < depth) && (!pol_en || (k % 2) != m_pol);
    for (int i = 0; i < nvc; i++) begin
      v = (m_rr + i) % nvc;
      if (!e_valid && mq[v].size() > 0 && (!pol_en || (v % 2) == m_pol)) begin
        e_valid = 1'b1;
        e_vc    = v;
      end
    end
    if (e_valid) begin
      head = mq[e_vc][0];
      hx   = head[55:52];
      hy   = head[51:48];
      if (hx != 4'd0) begin
        e_req  = head[63-vcb] ? 5'b00100 : 5'b01000;
        e_data = head - (64'd1 << 52);
      end else if (hy != 4'd0) begin
        e_req  = head[62-vcb] ? 5'b00010 : 5'b00001;
        e_data = head - (64'd1 << 48);
      end else begin
        e_req  = 5'b10000;
        e_data = head;
      end
    end
  endfunction

  function automatic void model_update();
    int nvc, vin;
    nvc = act ? 4 : 2;
    vin = act ? int'(cur_d[63:62]) : int'(cur_d[63]);
    if (e_valid && cur_g) begin
      void'(mq[e_vc].pop_front());
      m_rr = (e_vc + 1) % nvc;
    end
    if (cur_s) begin
      if (e_ri[vin]) mq[vin].push_back(cur_d);
      else m_err = 1'b1;
    end
    m_pol = 1 - m_pol;
  endfunction

  function automatic logic [63:0] rand_flit(input int vc);
    logic [63:0] f;
    f = {$urandom, $urandom};
    case ($urandom_range(3))
      0:       f[55:48] = 8'h00;
      1:       f[55:52] = 4'h0;
      default: ;
    endcase
    if (act) f[63:62] = 2'(vc);
    else     f[63]    = 1'(vc);
    return f;
  endfunction

  function automatic int pick_vc();
    int n;
    int cand[$];
    n = act ? 4 : 2;
    model_eval();
    for (int v = 0; v < n; v++) if (e_ri[v]) cand.push_back(v);
    if (cand.size() > 0 && $urandom_range(7) != 0) return cand[$urandom_range(cand.size() - 1)];
    return int'($urandom_range(n - 1));
  endfunction

  task automatic drive_check(input bit s, input logic [63:0] d, input bit g);
    @(negedge clk);
    si_a  = s && !act;
    si_b  = s && act;
    di    = d;
    grant = g;
    cur_s = s; cur_d = d; cur_g = g;
    #1;
    model_eval();
    check_eq("out_valid", act ? 64'(b_valid) : 64'(a_valid), 64'(e_valid));
    check_eq("out_req", act ? 64'(b_req) : 64'(a_req), 64'(e_req));
    check_eq("out_vc", act ? 64'(b_vc) : 64'(a_vc), 64'(e_vc));
    check_eq("out_data", act ? b_data : a_data, e_data);
    check_eq("ri", act ? 64'(b_ri) : 64'(a_ri), 64'(e_ri));
    check_eq("polarity", act ? 64'(b_pol) : 64'(a_pol), 64'(m_pol));
    check_eq("err_overflow", act ? 64'(b_err) : 64'(a_err), 64'(m_err));
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input bit s, input logic [63:0] d, input bit g);
    drive_check(s, d, g);
    finish_cycle();
  endtask

  task automatic wait_pol(input int p);
    while (m_pol != p) step(1'b0, 64'd0, 1'b0);
  endtask

  task automatic check_rst(input string tag);
    check_eq({tag, "_valid"}, act ? 64'(b_valid) : 64'(a_valid), 64'd0);
    check_eq({tag, "_req"}, act ? 64'(b_req) : 64'(a_req), 64'd0);
    check_eq({tag, "_vc"}, act ? 64'(b_vc) : 64'(a_vc), 64'd0);
    check_eq({tag, "_data"}, act ? b_data : a_data, 64'd0);
    check_eq({tag, "_ri"}, act ? 64'(b_ri) : 64'(a_ri), 64'd0);
    check_eq({tag, "_pol"}, act ? 64'(b_pol) : 64'(a_pol), 64'd0);
    check_eq({tag, "_err"}, act ? 64'(b_err) : 64'(a_err), 64'd0);
  endtask

  // Entered right after a rising edge; leaves just after a rising edge with reset released.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    si_a  = 1'b0;
    si_b  = 1'b0;
    grant = 1'b0;
    #1;
    check_rst("rst_now");
    model_reset();
    repeat (4) begin
      @(negedge clk);
      check_rst("rst_hold");
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] f;
    reset = 1'b1; si_a = 1'b0; si_b = 1'b0; di = '0; grant = 1'b0; act = 1'b0;
    model_reset();

    // Reset and phase
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_check(1'b0, 64'd0, 1'b0);
      check_eq("t1_pol", 64'(a_pol), 64'(k % 2));
      check_eq("t1_ri", 64'(a_ri), (k % 2) != 0 ? 64'd1 : 64'd2);
      finish_cycle();
    end

    // X routing
    wait_pol(1);
    step(1'b1, 64'h4021_0000_0000_0000, 1'b0);
    drive_check(1'b0, 64'd0, 1'b1);
    check_eq("t2_req", 64'(a_req), 64'h04);
    check_eq("t2_data", a_data, 64'h4011_0000_0000_0000);
    finish_cycle();
    step(1'b0, 64'd0, 1'b0);
    drive_check(1'b0, 64'd0, 1'b0);
    check_eq("t2_empty", 64'(a_valid), 64'd0);
    finish_cycle();

    // Y routing and local delivery
    wait_pol(0);
    step(1'b1, 64'hA003_0000_0000_0000, 1'b0);
    drive_check(1'b0, 64'd0, 1'b1);
    check_eq("t3_req_y", 64'(a_req), 64'h02);
    check_eq("t3_data_y", a_data, 64'hA002_0000_0000_0000);
    finish_cycle();
    step(1'b1, 64'h8000_0000_0000_0000, 1'b0);
    drive_check(1'b0, 64'd0, 1'b1);
    check_eq("t3_req_nic", 64'(a_req), 64'h10);
    check_eq("t3_data_nic", a_data, 64'h8000_0000_0000_0000);
    finish_cycle();

    // Fill and overflow on vc0
    wait_pol(1);
    step(1'b1, rand_flit(0), 1'b0);
    step(1'b0, 64'd0, 1'b0);
    step(1'b1, rand_flit(0), 1'b0);
    step(1'b0, 64'd0, 1'b0);
    drive_check(1'b1, rand_flit(0), 1'b0);
    check_eq("t4_full", 64'(a_ri[0]), 64'd0);
    finish_cycle();
    drive_check(1'b0, 64'd0, 1'b1);
    check_eq("t4_err", 64'(a_err), 64'd1);
    finish_cycle();
    drive_check(1'b0, 64'd0, 1'b0);
    check_eq("t4_ri_back", 64'(a_ri[0]), 64'd1);
    finish_cycle();
    step(1'b0, 64'd0, 1'b1);
    step(1'b0, 64'd0, 1'b0);

    // Reset mid-operation with three flits buffered
    wait_pol(1);
    step(1'b1, rand_flit(0), 1'b0);
    step(1'b1, rand_flit(1), 1'b0);
    step(1'b1, rand_flit(0), 1'b0);
    drive_check(1'b0, 64'd0, 1'b0);
    check_eq("t6_pre_valid", 64'(a_valid), 64'd1);
    finish_cycle();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive_check(1'b0, 64'd0, $urandom_range(1) != 0);
      check_eq("t6_no_stale", 64'(a_valid), 64'd0);
      finish_cycle();
    end

    // Random traffic, instance A
    for (int k = 0; k < 400; k++) begin
      f = rand_flit(pick_vc());
      step($urandom_range(3) != 0, f, $urandom_range(3) != 0);
    end

    // Round-robin on instance B
    act = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, rand_flit(k / 2), 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive_check(1'b0, 64'd0, 1'b1);
      check_eq("t5_rr", 64'(b_vc), 64'(k % 4));
      finish_cycle();
    end
    drive_check(1'b0, 64'd0, 1'b0);
    check_eq("t5_drained", 64'(b_valid), 64'd0);
    finish_cycle();

    // Random traffic, instance B
    for (int k = 0; k < 500; k++) begin
      f = rand_flit(pick_vc());
      step($urandom_range(3) != 0, f, $urandom_range(2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_input_unit_param.md
Name: router_input_unit_param

Overview:
- Parametrised per-port input unit for the next-generation mesh router.
- Replaces the fixed single-deep, two-VC input buffer with NUM_VC virtual-channel FIFOs of DEPTH entries each.
- Performs XY route computation with hop decrement on the head flit, and arbitrates the VC heads round-robin onto one crossbar request interface.
- Optional even/odd polarity mode keeps the legacy two-phase VC behaviour.

Parameters:
DATA_W  64  flit width
NUM_VC  2  virtual channels (power of 2, >=2); VCB = clog2(NUM_VC)
DEPTH  2  entries per VC FIFO (power of 2, >=2)
HOP_W  4  hop-count field width
POLARITY_EN  1  1 = legacy even/odd VC phasing; 0 = all VCs always eligible

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
si  input  1  upstream flit valid
di  input  DATA_W  upstream flit
ri  output  NUM_VC  per-VC ready to upstream
out_valid  output  1  head flit presented to crossbar
out_data  output  DATA_W  head flit, hop field decremented
out_req  output  5  one-hot destination: [0]up [1]down [2]left [3]right [4]NIC
out_vc  output  VCB  VC of presented flit
out_grant  input  1  crossbar accepts presented flit this cycle
polarity  output  1  current phase
err_overflow  output  1  sticky: flit arrived for a full or ineligible VC

Behaviour:
- Flit fields:
  - vc = di[DATA_W-1 -: VCB]
  - dirX = bit DATA_W-VCB-1 (0 = right, 1 = left)
  - dirY = bit DATA_W-VCB-2 (0 = up, 1 = down)
  - hopX = [DATA_W-9 -: HOP_W]
  - hopY = [DATA_W-9-HOP_W -: HOP_W]
  - Constraint: VCB+2 <= 8.
  - For the defaults this is bit63 vc, 62 dirX, 61 dirY, 55:52 hopX, 51:48 hopY.
- Reset (reset=0, asynchronous):
  - All FIFOs empty, all pointers 0, round-robin pointer 0.
  - polarity=0, err_overflow=0, out_valid=0, out_req=0, out_vc=0, out_data=0.
  - ri=0 while reset is asserted.
  - Reset asserted mid-operation discards all buffered flits.
- Polarity: register toggles every clk after reset deasserts.
- ri[v]:
  - POLARITY_EN=1: ri[v] = !full[v] && (v[0] != polarity).
  - POLARITY_EN=0: ri[v] = !full[v].
  - ri depends only on registered state, never on out_grant (no full-FIFO pass-through).
- Push: at the clk edge when si && ri[vc], di is written to FIFO[vc].
- Protocol violation: si with ri[vc]=0 drops the flit, sets err_overflow (sticky until reset), and leaves the FIFO unchanged.
- Eligibility: VC v is eligible when non-empty and (POLARITY_EN=0 or v[0]==polarity).
- Arbitration:
  - Combinational round-robin from rr_ptr over eligible VCs.
  - out_valid=1 iff any VC is eligible; out_vc = the selected VC.
- Head visibility: FIFOs are first-word fall-through. A flit pushed at edge N is eligible from cycle N+1; there is no same-cycle bypass.
- Route computation on the selected head (combinational):
  - hopX != 0: out_req = dirX ? left : right; out_data = head with hopX-1.
  - hopX == 0, hopY != 0: out_req = dirY ? down : up; out_data = head with hopY-1.
  - Both hop fields 0: out_req = NIC; out_data = head unchanged.
  - All other bits pass through unchanged. No wrap-around: a zero field is never decremented.
- Pop and pointer update:
  - out_valid && out_grant at an edge pops FIFO[out_vc] and sets rr_ptr = out_vc+1 mod NUM_VC.
  - Without a grant, rr_ptr holds and the same head stays presented while it remains eligible.
  - out_grant while out_valid=0 is ignored.
- Same-edge push and pop on the same non-full VC: both take effect, occupancy unchanged.
- out_data, out_req and out_vc are don't-care when out_valid=0 but must be driven 0 in that case.

Test Plan:
1. Reset and phase: hold reset=0 for 4 cycles, then release.
   -> all outputs 0 during reset; polarity toggles 0,1,0…; with POLARITY_EN=1, ri=2'b10 in polarity-0 cycles and 2'b01 in polarity-1 cycles.
2. X routing: push 64'h4021_0000_0000_0000 (vc0, dirX=1, hopX=2, hopY=1) when ri[0]=1.
   -> next eligible cycle: out_valid=1, out_req=5'b00100, out_data=64'h4011_0000_0000_0000; granting the flit empties the VC.
3. Y routing and local delivery:
   - push 64'hA003_… (vc1, dirY=1, hopY=3) -> out_req=5'b00010, out_data=64'hA002_….
   - push 64'h8000_… -> out_req=5'b10000, out_data unchanged.
4. Fill and overflow: push DEPTH flits to vc0 with out_grant=0.
   -> ri[0]=0; a further si on vc0 sets err_overflow=1 and the FIFO contents are unchanged.
   -> then one grant -> ri[0]=1 in the next cycle.
5. Round-robin: POLARITY_EN=0, NUM_VC=4, two flits queued in each VC, out_grant=1 continuously.
   -> out_vc sequence 0,1,2,3,0,1,2,3; no VC is starved.
6. Reset mid-operation: assert reset with 3 flits buffered.
   -> out_valid=0 immediately (asynchronous); after release, no stale flit appears.
